spm_arbiter: RTL and testbench

SPM_ARBITER -- requirements
Module: spm_arbiter

---
 rtl/spm_arbiter.sv | 141 ++++++++++++++
 tb/tb_spm_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_arbiter.sv
// Three-way scratchpad SRAM arbiter: round-robin grants with bounded burst locking.
// Optional per-requester grant/stall counters are enabled by defining SPM_ARB_PERF_EN.
module spm_arbiter #(
   parameter int AW       = 12,
   parameter int DW       = 16,
   parameter int MAX_HOLD = 8
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      req_valid,
   input  logic [2:0]      req_lock,
   input  logic [2:0]      req_we,
   input  logic [3*AW-1:0] req_addr,
   input  logic [3*DW-1:0] req_wdata,
   output logic [2:0]      req_ready,
   output logic [2:0]      rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata
`ifdef SPM_ARB_PERF_EN
   ,
   output logic [3*32-1:0] perf_grant,
   output logic [3*32-1:0] perf_stall
`endif
);

   typedef enum logic {ARB, HOLD} state_t;

   localparam logic [7:0] MAX_C = 8'(MAX_HOLD);

   state_t     state, state_nx;
   logic [1:0] ptr, ptr_nx, owner, owner_nx, gidx, cand;
   logic [7:0] hold_cnt, hold_nx;
   logic [2:0] gnt;
   logic       found;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x >= 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB;
         ptr       <= 2'd0;
         owner     <= 2'd0;
         hold_cnt  <= 8'd0;
         rsp_valid <= 3'b000;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         owner     <= owner_nx;
         hold_cnt  <= hold_nx;
         rsp_valid <= gnt & ~req_we;
      end
   end

   always_comb begin
      gnt      = 3'b000;
      gidx     = 2'd0;
      found    = 1'b0;
      cand     = ptr;
      state_nx = state;
      ptr_nx   = ptr;
      owner_nx = owner;
      hold_nx  = hold_cnt;
      case (state)
         ARB: begin
            for (int i = 0; i < 3; i++) begin
               if (!found && req_valid[cand]) begin
                  found = 1'b1;
                  gidx  = cand;
               end
               cand = inc3(cand);
            end
            if (found) begin
               gnt[gidx] = 1'b1;
               ptr_nx    = inc3(gidx);
               // a one-grant burst limit means the lock can never extend the burst
               if (req_lock[gidx] && MAX_C > 8'd1) begin
                  state_nx = HOLD;
                  owner_nx = gidx;
                  hold_nx  = 8'd1;
               end
            end
         end
         HOLD: begin
            ptr_nx = inc3(owner);
            if (req_valid[owner] && req_lock[owner]) begin
               found      = 1'b1;
               gidx       = owner;
               gnt[owner] = 1'b1;
               hold_nx    = hold_cnt + 8'd1;
               if (hold_cnt + 8'd1 >= MAX_C) begin
                  state_nx = ARB;
                  hold_nx  = 8'd0;
               end
            end else begin
               // owner released or went idle: spend this cycle idle, resume round-robin
               state_nx = ARB;
               hold_nx  = 8'd0;
            end
         end
         default: state_nx = ARB;
      endcase
   end

   assign req_ready = gnt;
   assign mem_en    = found;
   assign mem_we    = found & req_we[gidx];
   assign mem_addr  = found ? req_addr[gidx*AW +: AW]  : '0;
   assign mem_wdata = found ? req_wdata[gidx*DW +: DW] : '0;
   assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;

`ifdef SPM_ARB_PERF_EN
   logic [31:0] pg [3];
   logic [31:0] ps [3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            pg[i] <= 32'd0;
            ps[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (gnt[i] && pg[i] != 32'hFFFF_FFFF)
               pg[i] <= pg[i] + 32'd1;
            if (req_valid[i] && !gnt[i] && ps[i] != 32'hFFFF_FFFF)
               ps[i] <= ps[i] + 32'd1;
         end
      end
   end

   assign perf_grant = {pg[2], pg[1], pg[0]};
   assign perf_stall = {ps[2], ps[1], ps[0]};
`endif

endmodule

// File: tb/tb_spm_arbiter.sv
// Scoreboard bench for spm_arbiter: grant order checked per cycle, read data checked on rsp_valid.
module tb_spm_arbiter;
   localparam int AW = 12;
   localparam int DW = 16;
   localparam int MAX_HOLD = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      req_valid, req_lock, req_we, req_ready, rsp_valid;
   logic [3*AW-1:0] req_addr;
   logic [3*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
`ifdef SPM_ARB_PERF_EN
   logic [3*32-1:0] perf_grant, perf_stall;
`endif

   spm_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SPM_ARB_PERF_EN
      , .perf_grant(perf_grant), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // SRAM environment: 1-cycle read latency, write-then-read ordering
   logic [DW-1:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) sram[mem_addr] <= mem_wdata;
         else        mem_rdata      <= sram[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int due; int idx; logic [DW-1:0] data;} exp_t;
   exp_t          exp_q[$];
   logic [DW-1:0] ref_mem [int];
   int            n_tests = 0;
   int            n_fail = 0;

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'(a * 7 + 3);
   endfunction

   function automatic logic [AW-1:0] addr_of(input int g, input int k);
      return AW'(g * 256 + k);
   endfunction

   task automatic clr_req();
      req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic set_req(input int g, input bit v, input bit l, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[g] = v;
      req_lock[g]  = l;
      req_we[g]    = w;
      req_addr[g*AW +: AW]  = a;
      req_wdata[g*DW +: DW] = d;
   endtask

   // Record the effect of the access the bench expects requester g to win this cycle
   task automatic push_exp(input int g);
      exp_t e;
      int   a;
      a = int'(req_addr[g*AW +: AW]);
      if (req_we[g]) begin
         ref_mem[a] = req_wdata[g*DW +: DW];
      end else begin
         e.due  = cyc + 1;
         e.idx  = g;
         e.data = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr_req();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr_req();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b000 || mem_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_mem: ready=%b en=%b addr=%h wdata=%h, want all 0", req_ready, mem_en, mem_addr, mem_wdata);
      end
      n_tests++;
      if (rsp_valid !== 3'b000 || rsp_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: rsp_valid=%b rdata=%h, want 0", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b000 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL idle: ready=%b en=%b, want 0", req_ready, mem_en);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      int eg;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         for (int g = 0; g < 3; g++) set_req(g, 1, 0, 0, addr_of(g, k), '0);
         @(negedge clk);
         eg = k % 3;
         n_tests++;
         if (req_ready !== 3'(1 << eg) || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr_of(eg, k)) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: ready=%b addr=%h, want ready=%b addr=%h", k, req_ready, mem_addr, 3'(1 << eg), addr_of(eg, k));
         end
         push_exp(eg);
         @(posedge clk); #1;
      end
      clr_req();
      @(negedge clk);
`ifdef SPM_ARB_PERF_EN
      n_tests++;
      if (perf_grant !== {32'd2, 32'd2, 32'd2} || perf_stall !== {32'd4, 32'd4, 32'd4}) begin
         n_fail++;
         $display("FAIL perf: grant=%h stall=%h, want {2,2,2}/{4,4,4}", perf_grant, perf_stall);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_lock();
      int seq [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0, 1};
      do_reset();
      for (int k = 0; k < 12; k++) begin
         for (int g = 0; g < 3; g++) set_req(g, 1, (g == 1), 0, addr_of(g, 16 + k), '0);
         @(negedge clk);
         n_tests++;
         if (req_ready !== 3'(1 << seq[k])) begin
            n_fail++;
            $display("FAIL lock_grant[%0d]: ready=%b, want %b", k, req_ready, 3'(1 << seq[k]));
         end
         push_exp(seq[k]);
         @(posedge clk); #1;
      end
      clr_req();
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      do_reset();
      set_req(2, 1, 0, 1, 12'h200, 16'h7FFF);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b100 || mem_we !== 1'b1 || mem_addr !== 12'h200 || mem_wdata !== 16'h7FFF) begin
         n_fail++;
         $display("FAIL wr_cycle: ready=%b we=%b addr=%h wdata=%h, want 100/1/200/7fff", req_ready, mem_we, mem_addr, mem_wdata);
      end
      push_exp(2);
      @(posedge clk); #1;
      clr_req();
      set_req(0, 1, 0, 0, 12'h200, '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b001 || mem_we !== 1'b0 || rsp_valid !== 3'b000) begin
         n_fail++;
         $display("FAIL rd_cycle: ready=%b we=%b rsp_valid=%b, want 001/0/000", req_ready, mem_we, rsp_valid);
      end
      push_exp(0);
      @(posedge clk); #1;
      clr_req();
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 3'b001 || rsp_rdata !== 16'h7FFF) begin
         n_fail++;
         $display("FAIL wr_rd_data: rsp_valid=%b rdata=%h, want 001/7fff", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      set_req(1, 1, 0, 0, addr_of(1, 40), '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b010) begin
         n_fail++;
         $display("FAIL inflight_grant: ready=%b, want 010", req_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      clr_req();
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 3'b000 || rsp_rdata !== '0) begin
         n_fail++;
         $display("FAIL inflight_drop: rsp_valid=%b rdata=%h, want 0", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int g = 0; g < 3; g++) set_req(g, 1, 0, 0, addr_of(g, 41), '0);
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 3'b000 || req_ready !== 3'b001) begin
         n_fail++;
         $display("FAIL post_reset: rsp_valid=%b ready=%b, want 000/001", rsp_valid, req_ready);
      end
      push_exp(0);
      @(posedge clk); #1;
      clr_req();
      @(posedge clk); #1;
   endtask

   task automatic test_lock_drop();
      do_reset();
      set_req(1, 1, 1, 0, addr_of(1, 50), '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b010) begin
         n_fail++;
         $display("FAIL drop_first: ready=%b, want 010", req_ready);
      end
      push_exp(1);
      @(posedge clk); #1;
      set_req(0, 1, 0, 0, addr_of(0, 51), '0);
      set_req(1, 1, 1, 0, addr_of(1, 51), '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b010) begin
         n_fail++;
         $display("FAIL drop_hold: ready=%b, want 010", req_ready);
      end
      push_exp(1);
      @(posedge clk); #1;
      set_req(1, 0, 1, 0, addr_of(1, 52), '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b000 || mem_en !== 1'b0 || mem_addr !== '0) begin
         n_fail++;
         $display("FAIL drop_idle: ready=%b en=%b addr=%h, want 000/0/0", req_ready, mem_en, mem_addr);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b001) begin
         n_fail++;
         $display("FAIL drop_next: ready=%b, want 001", req_ready);
      end
      push_exp(0);
      @(posedge clk); #1;
      clr_req();
      @(posedge clk); #1;
   endtask

   task automatic test_unlock_exit();
      do_reset();
      set_req(2, 1, 1, 0, addr_of(2, 60), '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b100) begin
         n_fail++;
         $display("FAIL unlock_first: ready=%b, want 100", req_ready);
      end
      push_exp(2);
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) set_req(g, 1, 0, 0, addr_of(g, 61), '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b000 || mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL unlock_idle: ready=%b en=%b, want 000/0", req_ready, mem_en);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 3'b001) begin
         n_fail++;
         $display("FAIL unlock_wrap: ready=%b, want 001", req_ready);
      end
      push_exp(0);
      @(posedge clk); #1;
      clr_req();
      @(posedge clk); #1;
   endtask

   initial begin
      exp_t e;
      for (int a = 0; a < (1 << AW); a++) sram[a] = init_val(a);
      clr_req();
      // scoreboard consumer: every rsp_valid cycle must match the oldest due expectation
      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                  e = exp_q.pop_front();
                  n_tests++;
                  if (e.due != cyc || rsp_valid !== 3'(1 << e.idx) || rsp_rdata !== e.data) begin
                     n_fail++;
                     $display("FAIL rsp: cyc=%0d rsp_valid=%b rdata=%h, want due=%0d valid=%b rdata=%h",
                              cyc, rsp_valid, rsp_rdata, e.due, 3'(1 << e.idx), e.data);
                  end
               end else if (rsp_valid !== 3'b000 || rsp_rdata !== '0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL rsp_spurious: cyc=%0d rsp_valid=%b rdata=%h, want 0", cyc, rsp_valid, rsp_rdata);
               end
            end
         end
      join_none

      test_reset();
      test_round_robin();
      test_lock();
      test_write_read();
      test_reset_inflight();
      test_lock_drop();
      test_unlock_exit();

      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d responses outstanding, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
